// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, funct codes, ALU control encoding and control bundle
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7
  } alu_ctl_t;
  typedef struct packed {
    logic     reg_dst;
    logic     alu_src;
    logic     mem_to_reg;
    logic     reg_write;
    logic     mem_write;
    logic     branch;
    logic     jump;
    alu_ctl_t alu_ctl;
  } ctrl_t;
  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/mips_alu.sv
// mips_alu: 32-bit ALU with and/or/add/sub/signed-slt and zero flag
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_ctl_t    alu_ctl,
  output logic [31:0] result,
  output logic        zero
);
  // result select; anything unrecognised falls back to add
  always_comb begin
    result = alu_ctl == ALU_AND ? a & b :
             alu_ctl == ALU_OR  ? a | b :
             alu_ctl == ALU_SUB ? a - b :
             alu_ctl == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} :
                                  a + b;
    zero = result == 32'd0;
  end
endmodule

// File: rtl/mips_single_cycle.sv
// mips_single_cycle: single-cycle MIPS subset CPU (R-type, addi, lw, sw, beq, j)
module mips_single_cycle
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  logic [31:0] pc, pc4, pc_next, instr, imm, rs_val, rt_val, alu_b, alu_res, rdata, wd;
  logic [5:0]  op, fn;
  logic [4:0]  wa;
  logic        zero;
  ctrl_t       c;
  assign op  = instr[31:26];
  assign fn  = instr[5:0];
  assign imm = sext(instr[15:0]);
  assign pc4 = pc + 32'd4;
  // PC register; asynchronous reset restarts execution at address 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else pc <= pc_next;
  if (1) begin : Inst_mem
    logic [31:0] mem [0:IMEM_DEPTH-1];
    assign instr = mem[pc[IAW+1:2]];
  end
  // main control: decode opcode/funct; unknown encodings become NOPs
  always_comb begin
    c = '0;
    c.alu_ctl = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        c.reg_dst = 1'b1;
        c.reg_write = fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        c.alu_ctl = fn == FN_SUB ? ALU_SUB :
                    fn == FN_AND ? ALU_AND :
                    fn == FN_OR  ? ALU_OR  :
                    fn == FN_SLT ? ALU_SLT : ALU_ADD;
      end
      OP_ADDI: begin
        c.alu_src = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_LW: begin
        c.alu_src = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_SW: begin
        c.alu_src = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_ctl = ALU_SUB;
      end
      OP_J: c.jump = 1'b1;
      default: ;
    endcase
  end
  assign wa = c.reg_dst ? instr[15:11] : instr[20:16];
  assign wd = c.mem_to_reg ? rdata : alu_res;
  if (1) begin : RegFile
    logic [31:0] RF [0:31];
    // write port; suppressed while reset is held so preloads survive
    always_ff @(posedge clk)
      if (rst_n && c.reg_write && wa != 5'd0) RF[wa] <= wd;
    assign rs_val = instr[25:21] == 5'd0 ? 32'd0 : RF[instr[25:21]];
    assign rt_val = instr[20:16] == 5'd0 ? 32'd0 : RF[instr[20:16]];
  end
  assign alu_b = c.alu_src ? imm : rt_val;
  mips_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .alu_ctl(c.alu_ctl),
    .result (alu_res),
    .zero   (zero)
  );
  if (1) begin : data_mem
    logic [31:0] mem [0:DMEM_DEPTH-1];
    // store port; suppressed while reset is held
    always_ff @(posedge clk)
      if (rst_n && c.mem_write) mem[alu_res[DAW+1:2]] <= rt_val;
    assign rdata = mem[alu_res[DAW+1:2]];
  end
  assign pc_next = c.jump ? {pc4[31:28], instr[25:0], 2'b00} :
                   c.branch && zero ? pc4 + {imm[29:0], 2'b00} : pc4;
  assign pc_out = pc;
  assign instr_out = instr;
endmodule

// File: tb/tb_mips_single_cycle.sv
// tb_mips_single_cycle: directed program with hand-computed register/RAM/PC checks
module tb_mips_single_cycle;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] pc_out, instr_out;
  int n_cmp = 0;
  int n_bad = 0;

  mips_single_cycle dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_out   (pc_out),
    .instr_out(instr_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] jt(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) dut.Inst_mem.mem[k] = 32'h0;
    for (int k = 0; k < 32; k++) dut.RegFile.RF[k] = 32'h0;
    dut.RegFile.RF[1] = 32'd5;
    dut.RegFile.RF[2] = 32'd3;
    dut.data_mem.mem[1] = 32'h1234;
    dut.Inst_mem.mem[0]  = r(1, 2, 3, 6'h20);
    dut.Inst_mem.mem[1]  = r(1, 2, 4, 6'h22);
    dut.Inst_mem.mem[2]  = r(1, 2, 5, 6'h24);
    dut.Inst_mem.mem[3]  = r(1, 2, 6, 6'h25);
    dut.Inst_mem.mem[4]  = it(6'h04, 1, 1, 16'd2);
    dut.Inst_mem.mem[5]  = it(6'h08, 0, 10, 16'd99);
    dut.Inst_mem.mem[6]  = it(6'h08, 0, 10, 16'd99);
    dut.Inst_mem.mem[7]  = r(2, 1, 7, 6'h2A);
    dut.Inst_mem.mem[8]  = jt(26'h10);
    dut.Inst_mem.mem[9]  = it(6'h08, 0, 12, 16'd7);
    dut.Inst_mem.mem[16] = it(6'h08, 0, 8, 16'hFFFC);
    dut.Inst_mem.mem[17] = it(6'h2B, 0, 1, 16'd8);
    dut.Inst_mem.mem[18] = it(6'h23, 0, 9, 16'd8);
    dut.Inst_mem.mem[19] = it(6'h04, 1, 2, 16'd5);
    dut.Inst_mem.mem[20] = r(1, 2, 0, 6'h20);
    dut.Inst_mem.mem[21] = it(6'h3F, 0, 10, 16'd4);
    dut.Inst_mem.mem[22] = jt(26'h09);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_instr", instr_out, 32'h00221820);
    @(negedge clk) rst_n = 1'b1;
    chk("reset_held_rf3", dut.RegFile.RF[3], 32'h0);
    tick; chk("pc_04", pc_out, 32'h04); chk("add", dut.RegFile.RF[3], 32'd8);
    tick; chk("pc_08", pc_out, 32'h08); chk("sub", dut.RegFile.RF[4], 32'd2);
    tick; chk("pc_0c", pc_out, 32'h0C); chk("and", dut.RegFile.RF[5], 32'd1);
    tick; chk("pc_10", pc_out, 32'h10); chk("or", dut.RegFile.RF[6], 32'd7);
    tick; chk("beq_taken", pc_out, 32'h1C);
    tick; chk("pc_20", pc_out, 32'h20); chk("slt", dut.RegFile.RF[7], 32'd1);
    chk("skipped_slots", dut.RegFile.RF[10], 32'd0);
    tick; chk("jump", pc_out, 32'h40);
    tick; chk("addi_neg", dut.RegFile.RF[8], 32'hFFFFFFFC);
    tick; chk("sw", dut.data_mem.mem[2], 32'd5);
    tick; chk("lw", dut.RegFile.RF[9], 32'd5); chk("pc_4c", pc_out, 32'h4C);
    tick; chk("beq_not_taken", pc_out, 32'h50);
    tick; chk("r0_zero", dut.RegFile.RF[0], 32'd0); chk("pc_54", pc_out, 32'h54);
    tick; chk("undef_pc", pc_out, 32'h58);
    chk("undef_rf", dut.RegFile.RF[10], 32'd0);
    chk("undef_ram", dut.data_mem.mem[1], 32'h1234);
    tick; chk("jump_back", pc_out, 32'h24);
    chk("instr_24", instr_out, 32'h200C0007);
    #3 rst_n = 1'b0;
    #1;
    chk("async_pc", pc_out, 32'h0);
    chk("async_instr", instr_out, 32'h00221820);
    tick;
    chk("hold_pc", pc_out, 32'h0);
    chk("rf12_kept", dut.RegFile.RF[12], 32'd0);
    chk("rf3_kept", dut.RegFile.RF[3], 32'd8);
    chk("rf9_kept", dut.RegFile.RF[9], 32'd5);
    @(negedge clk) rst_n = 1'b1;
    tick; chk("resume_pc", pc_out, 32'h04);
    chk("resume_rf3", dut.RegFile.RF[3], 32'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
